// File: rtl/bayer_stream_tx_pkg.sv
// Shared widths, colour/stage codes and CFA phases for the Bayer stream
// transmitter and its helpers.
package bayer_stream_tx_pkg;

  localparam int COLOR_DEPTH   = 10;
  localparam int COLOR_BIT_CNT = 2;
  localparam int MODE_BIT_CNT  = 4;

  localparam logic [COLOR_BIT_CNT-1:0] RED   = 2'd0;
  localparam logic [COLOR_BIT_CNT-1:0] GREEN = 2'd1;
  localparam logic [COLOR_BIT_CNT-1:0] BLUE  = 2'd2;
  localparam logic [COLOR_BIT_CNT-1:0] VOID  = 2'd3;

  localparam logic [MODE_BIT_CNT-1:0] STAGE11 = 4'd1;
  localparam logic [MODE_BIT_CNT-1:0] STAGE12 = 4'd2;
  localparam logic [MODE_BIT_CNT-1:0] STAGE21 = 4'd3;
  localparam logic [MODE_BIT_CNT-1:0] STAGE22 = 4'd4;
  localparam logic [MODE_BIT_CNT-1:0] STAGE31 = 4'd5;

  localparam int CFA_RGGB = 0;
  localparam int CFA_GRBG = 1;
  localparam int CFA_GBRG = 2;
  localparam int CFA_BGGR = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FIN
  } state_e;

  // Sideband that travels with each SRAM read until its pixel is presented.
  typedef struct packed {
    logic [COLOR_BIT_CNT-1:0] color;
    logic                     last_col;
    logic                     last_pic;
  } tag_t;

endpackage

// File: rtl/bayer_stream_tx_label.sv
// Combinational Bayer colour label: (row lsb, col lsb, CFA phase) -> colour.
module bayer_cfa_label
  import bayer_stream_tx_pkg::*;
(
  input  logic                     row_lsb,
  input  logic                     col_lsb,
  input  logic [1:0]               cfa,
  output logic [COLOR_BIT_CNT-1:0] color
);

  // Every phase is the RGGB grid shifted: cfa[1] flips rows, cfa[0] flips columns.
  always_comb begin
    color = GREEN;
    case ({row_lsb ^ cfa[1], col_lsb ^ cfa[0]})
      2'b00:   color = RED;
      2'b11:   color = BLUE;
      default: color = GREEN;
    endcase
  end

endmodule

// File: rtl/bayer_stream_tx.sv
// Streams a Bayer RAW frame from a 1-cycle-latency frame SRAM to the ISP
// pixel interface, one pixel per cycle, with stall support.
module bayer_stream_tx
  import bayer_stream_tx_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 12,
  parameter int CFA    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [DIM_W-1:0]         width_i,
  input  logic [DIM_W-1:0]         height_i,
  input  logic [MODE_BIT_CNT-1:0]  mode_i,
  input  logic                     stall_i,
  output logic                     mem_rd_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [COLOR_DEPTH-1:0]   mem_rdata_i,
  output logic [COLOR_DEPTH-1:0]   pixel_o,
  output logic                     valid_o,
  output logic [COLOR_BIT_CNT-1:0] color_o,
  output logic                     last_col_o,
  output logic                     last_pic_o,
  output logic [MODE_BIT_CNT-1:0]  mode_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [1:0] CFA_PH = 2'(CFA);

  state_e                   state, state_nx;
  logic [DIM_W-1:0]         width_q, height_q;
  logic [DIM_W-1:0]         row, col;
  logic                     start_ok, zero_dim;
  logic                     issue, col_end, row_end, last_read;
  logic [COLOR_BIT_CNT-1:0] issue_color;

  logic                     tag_v;
  tag_t                     tag_q;
  logic                     hold_v;
  tag_t                     hold_tag;
  logic [COLOR_DEPTH-1:0]   hold_pix;

  logic                     load;
  tag_t                     load_tag;
  logic [COLOR_DEPTH-1:0]   load_pix;

  // done_o keeps the block busy for its pulse so a start cannot overlap it.
  assign start_ok  = start_i && (state == ST_IDLE) && !done_o;
  assign zero_dim  = (width_i == '0) || (height_i == '0);
  assign issue     = (state == ST_FETCH) && !stall_i;
  assign col_end   = (col == width_q - DIM_W'(1));
  assign row_end   = (row == height_q - DIM_W'(1));
  assign last_read = col_end && row_end;
  assign mem_rd_o  = issue;
  assign busy_o    = (state != ST_IDLE) || done_o;

  bayer_cfa_label u_label (
    .row_lsb (row[0]),
    .col_lsb (col[0]),
    .cfa     (CFA_PH),
    .color   (issue_color)
  );

  // Held data is older than anything in flight, so it always goes out first.
  always_comb begin
    load     = !stall_i && (hold_v || tag_v);
    load_tag = hold_v ? hold_tag : tag_q;
    load_pix = hold_v ? hold_pix : mem_rdata_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nx = zero_dim ? ST_FIN : ST_FETCH;
      ST_FETCH: if (issue && last_read) state_nx = ST_DRAIN;
      ST_DRAIN: if (load && load_tag.last_pic) state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_o <= 1'b0;
    end else begin
      state  <= state_nx;
      done_o <= (state == ST_FIN);
    end
  end

  // Frame geometry and read address; the address simply counts issued reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q    <= '0;
      height_q   <= '0;
      mode_o     <= STAGE11;
      row        <= '0;
      col        <= '0;
      mem_addr_o <= '0;
    end else if (start_ok) begin
      width_q    <= width_i;
      height_q   <= height_i;
      mode_o     <= mode_i;
      row        <= '0;
      col        <= '0;
      mem_addr_o <= '0;
    end else if (issue) begin
      mem_addr_o <= mem_addr_o + ADDR_W'(1);
      if (col_end) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= 1'b0;
      tag_q <= '0;
    end else begin
      tag_v <= issue;
      if (issue) begin
        tag_q.color    <= issue_color;
        tag_q.last_col <= col_end;
        tag_q.last_pic <= last_read;
      end
    end
  end

  // A read returning while stalled is parked; no new read can follow it
  // until the stall drops, so one entry is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v   <= 1'b0;
      hold_tag <= '0;
      hold_pix <= '0;
    end else if (stall_i && tag_v) begin
      hold_v   <= 1'b1;
      hold_tag <= tag_q;
      hold_pix <= mem_rdata_i;
    end else if (!stall_i) begin
      hold_v   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      pixel_o    <= '0;
      color_o    <= VOID;
      last_col_o <= 1'b0;
      last_pic_o <= 1'b0;
    end else begin
      valid_o    <= load;
      pixel_o    <= load ? load_pix : '0;
      color_o    <= load ? load_tag.color : VOID;
      last_col_o <= load && load_tag.last_col;
      last_pic_o <= load && load_tag.last_pic;
    end
  end

endmodule

// File: tb/tb_bayer_stream_tx.sv
// Scoreboard bench for bayer_stream_tx: two DUTs (RGGB and BGGR) share stimulus.
module tb_bayer_stream_tx;
  import bayer_stream_tx_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DIM_W  = 12;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start_i = 1'b0;
  logic                    stall_i = 1'b0;
  logic [DIM_W-1:0]        width_i = '0;
  logic [DIM_W-1:0]        height_i = '0;
  logic [MODE_BIT_CNT-1:0] mode_i = '0;

  logic                     rd0, rd3;
  logic [ADDR_W-1:0]        addr0, addr3;
  logic [COLOR_DEPTH-1:0]   rdata0 = '0, rdata3 = '0;
  logic [COLOR_DEPTH-1:0]   pix0, pix3;
  logic                     v0, v3, lc0, lc3, lp0, lp3, busy0, busy3, done0, done3;
  logic [COLOR_BIT_CNT-1:0] col0, col3;
  logic [MODE_BIT_CNT-1:0]  mode0, mode3;

  always #5 clk = ~clk;

  bayer_stream_tx #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CFA(CFA_RGGB)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .width_i(width_i), .height_i(height_i),
    .mode_i(mode_i), .stall_i(stall_i), .mem_rd_o(rd0), .mem_addr_o(addr0),
    .mem_rdata_i(rdata0), .pixel_o(pix0), .valid_o(v0), .color_o(col0),
    .last_col_o(lc0), .last_pic_o(lp0), .mode_o(mode0), .busy_o(busy0), .done_o(done0));

  bayer_stream_tx #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CFA(CFA_BGGR)) u3 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .width_i(width_i), .height_i(height_i),
    .mode_i(mode_i), .stall_i(stall_i), .mem_rd_o(rd3), .mem_addr_o(addr3),
    .mem_rdata_i(rdata3), .pixel_o(pix3), .valid_o(v3), .color_o(col3),
    .last_col_o(lc3), .last_pic_o(lp3), .mode_o(mode3), .busy_o(busy3), .done_o(done3));

  // Frame SRAM: word i holds i+10, one-cycle read latency.
  logic [COLOR_DEPTH-1:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = COLOR_DEPTH'(i + 10);

  always @(posedge clk) begin
    if (rd0) rdata0 <= mem[addr0[7:0]];
    if (rd3) rdata3 <= mem[addr3[7:0]];
  end

  typedef struct {
    logic [COLOR_DEPTH-1:0]   pix;
    logic [COLOR_BIT_CNT-1:0] color;
    logic                     lc;
    logic                     lp;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int t0 = 0;
  int first_v = -1, last_pic_cyc = -1, done_cyc = -1;
  int busy_cnt = 0, done_cnt = 0, rd_cnt = 0, gap_cnt = 0;
  logic                    mode_chk = 1'b0;
  logic [MODE_BIT_CNT-1:0] exp_mode = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-written colour grids per CFA phase, indexed by (row%2)*2 + col%2.
  function automatic logic [COLOR_BIT_CNT-1:0] exp_color(input int cfa, input int r, input int c);
    int k;
    k = (r % 2) * 2 + (c % 2);
    exp_color = GREEN;
    case (cfa)
      0: case (k) 0: exp_color = RED;   3: exp_color = BLUE; default: exp_color = GREEN; endcase
      1: case (k) 1: exp_color = RED;   2: exp_color = BLUE; default: exp_color = GREEN; endcase
      2: case (k) 2: exp_color = RED;   1: exp_color = BLUE; default: exp_color = GREEN; endcase
      default: case (k) 3: exp_color = RED; 0: exp_color = BLUE; default: exp_color = GREEN; endcase
    endcase
  endfunction

  task automatic push_frame(input int w, input int h);
    exp_t e;
    for (int i = 0; i < w * h; i++) begin
      e.pix   = COLOR_DEPTH'(i + 10);
      e.lc    = ((i % w) == w - 1);
      e.lp    = (i == w * h - 1);
      e.color = exp_color(0, i / w, i % w);
      q0.push_back(e);
      e.color = exp_color(3, i / w, i % w);
      q3.push_back(e);
    end
  endtask

  task automatic mon_step(input int which, input logic v, input logic [COLOR_DEPTH-1:0] p,
                          input logic [COLOR_BIT_CNT-1:0] c, input logic lc, input logic lp);
    exp_t e;
    logic empty;
    if (v) begin
      empty = (which == 0) ? (q0.size() == 0) : (q3.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel dut%0d: got pixel %0d, expected none", which, p);
      end else begin
        if (which == 0) e = q0.pop_front();
        else            e = q3.pop_front();
        check($sformatf("pixel dut%0d", which), 32'(p), 32'(e.pix));
        check($sformatf("color dut%0d", which), 32'(c), 32'(e.color));
        check($sformatf("last_col dut%0d", which), 32'(lc), 32'(e.lc));
        check($sformatf("last_pic dut%0d", which), 32'(lp), 32'(e.lp));
      end
    end else begin
      check($sformatf("idle_color dut%0d", which), 32'(c), 32'(VOID));
      check($sformatf("idle_last dut%0d", which), 32'({lc, lp}), 32'(0));
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      busy_cnt += int'(busy0);
      done_cnt += int'(done0);
      rd_cnt   += int'(rd0);
      if (done0) done_cyc = ncyc;
      if (mode_chk && busy0) check("mode_o", 32'(mode0), 32'(exp_mode));
      mon_step(0, v0, pix0, col0, lc0, lp0);
      mon_step(3, v3, pix3, col3, lc3, lp3);
      if (v0) begin
        if (first_v < 0) first_v = ncyc;
        if (lp0) last_pic_cyc = ncyc;
      end else if (first_v >= 0 && last_pic_cyc < 0) begin
        gap_cnt++;
      end
    end
  end

  task automatic start_frame(input int w, input int h, input logic [MODE_BIT_CNT-1:0] m);
    @(posedge clk);
    #1;
    width_i = DIM_W'(w); height_i = DIM_W'(h); mode_i = m; start_i = 1'b1;
    exp_mode = m; mode_chk = 1'b1;
    first_v = -1; last_pic_cyc = -1; done_cyc = -1;
    busy_cnt = 0; done_cnt = 0; rd_cnt = 0; gap_cnt = 0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    t0 = ncyc;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("done_within_budget", 32'(done_cnt > 0), 32'(1));
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(v0), 32'(0));
    check({tag, "_pixel"}, 32'(pix0), 32'(0));
    check({tag, "_color"}, 32'(col0), 32'(VOID));
    check({tag, "_last"}, 32'({lc0, lp0}), 32'(0));
    check({tag, "_mode"}, 32'(mode0), 32'(STAGE11));
    check({tag, "_busy_done"}, 32'({busy0, done0}), 32'(0));
    check({tag, "_mem_rd"}, 32'(rd0), 32'(0));
    check({tag, "_mem_addr"}, 32'(addr0), 32'(0));
    check({tag, "_color_bggr"}, 32'(col3), 32'(VOID));
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 4x2 plain frame: latency, back-to-back pixels, done one cycle after last
    push_frame(4, 2);
    start_frame(4, 2, STAGE12);
    wait_done(40);
    check("plain_first_valid", 32'(first_v), 32'(t0 + 3));
    check("plain_last_pic", 32'(last_pic_cyc), 32'(t0 + 10));
    check("plain_done", 32'(done_cyc), 32'(t0 + 11));
    check("plain_gaps", 32'(gap_cnt), 32'(0));
    check("plain_reads", 32'(rd_cnt), 32'(8));
    check("plain_busy", 32'(busy_cnt), 32'(11));
    check("plain_drained", 32'(q0.size() + q3.size()), 32'(0));

    // 4x2 with a 3-cycle stall after the second read
    push_frame(4, 2);
    start_frame(4, 2, STAGE21);
    @(posedge clk);
    @(posedge clk);
    #1 stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr_hold", 32'(addr0), 32'(2));
      check("stall_no_read", 32'(rd0), 32'(0));
      @(posedge clk);
    end
    #1 stall_i = 1'b0;
    wait_done(40);
    check("stall_first_valid", 32'(first_v), 32'(t0 + 3));
    check("stall_gap", 32'(gap_cnt), 32'(3));
    check("stall_last_pic", 32'(last_pic_cyc), 32'(t0 + 13));
    check("stall_done", 32'(done_cyc), 32'(t0 + 14));
    check("stall_reads", 32'(rd_cnt), 32'(8));
    check("stall_drained", 32'(q0.size() + q3.size()), 32'(0));

    // zero width: no reads, no pixels, short done
    start_frame(0, 5, STAGE11);
    repeat (6) @(posedge clk);
    check("zero_reads", 32'(rd_cnt), 32'(0));
    check("zero_valid", 32'(first_v), 32'(-1));
    check("zero_busy", 32'(busy_cnt), 32'(2));
    check("zero_done_cnt", 32'(done_cnt), 32'(1));
    check("zero_done_cyc", 32'(done_cyc), 32'(t0 + 2));

    // odd 3x3 frame exercises colour phase on odd columns/rows
    push_frame(3, 3);
    start_frame(3, 3, STAGE12);
    wait_done(40);
    check("odd_last_pic", 32'(last_pic_cyc), 32'(t0 + 11));
    check("odd_reads", 32'(rd_cnt), 32'(9));
    check("odd_drained", 32'(q0.size() + q3.size()), 32'(0));

    // restart attempt mid-frame is ignored
    push_frame(4, 2);
    start_frame(4, 2, STAGE22);
    @(posedge clk);
    @(posedge clk);
    #1;
    width_i = DIM_W'(2); height_i = DIM_W'(1); mode_i = STAGE11; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(40);
    check("restart_last_pic", 32'(last_pic_cyc), 32'(t0 + 10));
    check("restart_reads", 32'(rd_cnt), 32'(8));
    check("restart_done_cnt", 32'(done_cnt), 32'(1));
    check("restart_mode_kept", 32'(mode0), 32'(STAGE22));
    check("restart_drained", 32'(q0.size() + q3.size()), 32'(0));

    // asynchronous reset in the middle of a 16x16 frame
    push_frame(16, 16);
    start_frame(16, 16, STAGE31);
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    q0.delete();
    q3.delete();
    mode_chk = 1'b0;
    done_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(0));

    push_frame(4, 2);
    start_frame(4, 2, STAGE11);
    @(negedge clk);
    check("after_abort_first_rd", 32'(rd0), 32'(1));
    check("after_abort_first_addr", 32'(addr0), 32'(0));
    wait_done(40);
    check("after_abort_last_pic", 32'(last_pic_cyc), 32'(t0 + 10));
    check("after_abort_drained", 32'(q0.size() + q3.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
